// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels
// used by both the transmitter and the matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES-1 down to 0, ticks on 0 and reloads.
// A restart pulse realigns the period to the cycle after the pulse.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic c,
  input  logic r,
  input  logic restart,
  output logic tick
);

  localparam int TW = $clog2(BIT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = cnt_q - TW'(1);
    if (restart || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge c) begin
    if (!r) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, W data bits LSB first, optional even parity,
// stop bit. tx, ready and busy are all registered.
module serial_tx
  import serial_pkg::*;
#(
  parameter int W          = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY     = 0
) (
  input  logic         c,
  input  logic         r,
  input  logic [W-1:0] data_in,
  input  logic         valid,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic [2:0]   state_dbg
);

  localparam int CW = $clog2(W + 1);

  // Handshake: a word is taken on a posedge where valid && ready; valid
  // without ready is ignored, and data_in is not looked at outside that edge.
  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           restart;
  logic           tick;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .c       (c),
    .r       (r),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    restart   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          shift_d   = data_in;
          par_d     = ^data_in;
          bit_cnt_d = '0;
          restart   = 1'b1;
          state_d   = START;
          tx_d      = START_BIT;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = CW'(1);
        end
      end
      DATA: begin
        // bit_cnt_q counts bits already put on the line, so W means done
        if (tick) begin
          if (bit_cnt_q == CW'(W)) begin
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = LINE_IDLE;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (!r) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign ready     = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three builds (no parity, parity, BIT_CYCLES=1) share
// clock, reset and data_in; each has its own valid.
module tb_serial_tx;

  localparam int W = 8;

  logic       c = 1'b0;
  logic       r;
  logic [7:0] din;
  logic [2:0] v;
  wire  [2:0] tx_w, rdy_w, busy_w;
  wire  [2:0] st0, st1, st2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  always #2 c = ~c;

  serial_tx #(.W(8), .BIT_CYCLES(4), .PARITY(0)) u_d0 (
    .c(c), .r(r), .data_in(din), .valid(v[0]), .ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .state_dbg(st0));
  serial_tx #(.W(8), .BIT_CYCLES(4), .PARITY(1)) u_d1 (
    .c(c), .r(r), .data_in(din), .valid(v[1]), .ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .state_dbg(st1));
  serial_tx #(.W(8), .BIT_CYCLES(1), .PARITY(0)) u_d2 (
    .c(c), .r(r), .data_in(din), .valid(v[2]), .ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .state_dbg(st2));

  function automatic int bc_of(int id);
    return (id == 2) ? 1 : 4;
  endfunction

  function automatic int par_of(int id);
    return (id == 1) ? 1 : 0;
  endfunction

  // Expected line level per cycle after the accept edge; bit k = cycle k.
  function automatic logic [63:0] model_stream(logic [7:0] w, int p, int bc);
    logic [63:0] s;
    logic        val;
    s = '1;
    for (int b = 0; b < W + 2 + p; b++) begin
      if (b == 0)                    val = 1'b0;
      else if (b <= W)               val = w[b-1];
      else if (b == W + 1 && p != 0) val = ^w;
      else                           val = 1'b1;
      for (int j = 0; j < bc; j++) s[b*bc + j] = val;
    end
    return s;
  endfunction

  task automatic offer(int id, logic [7:0] w);
    @(posedge c); #1;
    n_cmp++;
    if (rdy_w[id] !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_offer dut%0d got=%b want=1", id, rdy_w[id]);
    end
    din   = w;
    v[id] = 1'b1;
    exp_q.push_back(w);
  endtask

  // Waits for the accept edge, records the whole frame, then checks the
  // single idle cycle that follows it.
  task automatic watch_frame(int id, logic hold, logic [7:0] next_din);
    int          bc;
    int          len;
    logic [63:0] exp_s, obs_s;
    logic [7:0]  dec, want;
    logic        rdy_seen, busy_all;
    bc    = bc_of(id);
    len   = (W + 2 + par_of(id)) * bc;
    exp_s = model_stream(exp_q[0], par_of(id), bc);
    @(posedge c); #1;
    if (!hold) v[id] = 1'b0;
    else exp_q.push_back(next_din);
    din      = next_din;
    obs_s    = '1;
    rdy_seen = 1'b0;
    busy_all = 1'b1;
    dec      = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge c);
      obs_s[k] = tx_w[id];
      rdy_seen = rdy_seen | rdy_w[id];
      busy_all = busy_all & busy_w[id];
      if ((k % bc) == (bc / 2) && (k / bc) >= 1 && (k / bc) <= W)
        dec[k/bc - 1] = tx_w[id];
    end
    n_cmp++;
    if (obs_s !== exp_s) begin
      n_bad++;
      $display("FAIL tx_stream dut%0d got=%h want=%h", id, obs_s, exp_s);
    end
    n_cmp++;
    if (rdy_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_during_frame dut%0d got=%b want=0", id, rdy_seen);
    end
    n_cmp++;
    if (busy_all !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_during_frame dut%0d got=%b want=1", id, busy_all);
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (dec !== want) begin
      n_bad++;
      $display("FAIL decoded_word dut%0d got=%h want=%h", id, dec, want);
    end
    @(negedge c);
    n_cmp++;
    if ({tx_w[id], rdy_w[id], busy_w[id]} !== 3'b110) begin
      n_bad++;
      $display("FAIL idle_after_frame dut%0d tx/ready/busy got=%b want=110", id,
               {tx_w[id], rdy_w[id], busy_w[id]});
    end
  endtask

  task automatic test_reset();
    r   = 1'b0;
    v   = 3'b111;
    din = 8'hA5;
    repeat (3) begin
      @(posedge c);
      @(negedge c);
      n_cmp++;
      if ({tx_w, rdy_w, busy_w, st0, st1, st2} !== {3'b111, 3'b111, 3'b000, 9'd0}) begin
        n_bad++;
        $display("FAIL reset_outputs tx=%b ready=%b busy=%b st=%0d/%0d/%0d want tx=111 ready=111 busy=000 st=0",
                 tx_w, rdy_w, busy_w, st0, st1, st2);
      end
    end
    @(posedge c); #1;
    r = 1'b1;
    v = 3'b000;
    @(posedge c);
    @(negedge c);
    n_cmp++;
    if ({tx_w, rdy_w, busy_w} !== {3'b111, 3'b111, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_release tx=%b ready=%b busy=%b want tx=111 ready=111 busy=000",
               tx_w, rdy_w, busy_w);
    end
  endtask

  task automatic test_single_frame();
    offer(0, 8'hA5);
    watch_frame(0, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    offer(1, 8'hA5);
    watch_frame(1, 1'b0, 8'h00);
    offer(1, 8'h07);
    watch_frame(1, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    offer(0, 8'h01);
    watch_frame(0, 1'b1, 8'hFF);
    watch_frame(0, 1'b0, 8'h00);
  endtask

  task automatic test_ignore_busy();
    offer(0, 8'h5A);
    watch_frame(0, 1'b1, 8'h33);
    watch_frame(0, 1'b0, 8'h00);
  endtask

  task automatic test_mid_reset();
    logic [7:0] dropped;
    offer(0, 8'h55);
    @(posedge c); #1;
    v[0] = 1'b0;
    din  = 8'h00;
    repeat (17) @(posedge c);
    @(negedge c);
    n_cmp++;
    if ({tx_w[0], busy_w[0]} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_frame_bit3 tx/busy got=%b want=01", {tx_w[0], busy_w[0]});
    end
    r = 1'b0;
    @(posedge c); #1;
    r = 1'b1;
    @(negedge c);
    n_cmp++;
    if ({tx_w[0], rdy_w[0], busy_w[0], st0} !== {3'b110, 3'd0}) begin
      n_bad++;
      $display("FAIL abort_idle tx/ready/busy/state got=%b/%0d want=110/0",
               {tx_w[0], rdy_w[0], busy_w[0]}, st0);
    end
    dropped = exp_q.pop_front();
    offer(0, 8'h0F);
    watch_frame(0, 1'b0, 8'h00);
  endtask

  task automatic test_bit_cycles_one();
    offer(2, 8'hA5);
    watch_frame(2, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_mid_reset();
    test_bit_cycles_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
